// File: rtl/reg_file_loader_pkg.sv
// Shared definitions for the register-file loader.
// Holds the FSM state encoding, well-known register indices, the stack
// pointer restore value and the default data/index widths.
package reg_file_loader_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [4:0]  REG_SP   = 5'd29;
  localparam logic [31:0] SP_RESET = 32'h00001FFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/reg_file_loader.sv
// Sequential register-file loader: writes one accepted input word per cycle
// into registers FIRST_REG..LAST_REG through the register file's write port.
// Ports:
//   Clock, Reset        - clock and synchronous active-high reset
//   Start, Abort        - begin a load / cancel an in-progress load
//   In_Data, In_Valid   - input word stream
//   In_Ready            - word is accepted when In_Valid & In_Ready
//   Write_Reg/Data      - register-file write index and data
//   Reg_Write           - register-file write enable
//   Busy                - load in progress (top level muxes the write port)
//   Done                - one-cycle completion pulse
//   Loaded_Count        - words written in the current or most recent load
module reg_file_loader
  import reg_file_loader_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              In_Valid,
  output logic              In_Ready,
  output logic [ADDR_W-1:0] Write_Reg,
  output logic [DATA_W-1:0] Write_Data,
  output logic              Reg_Write,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W:0]   Loaded_Count
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   index_r, index_s;
  logic                in_ready_r, in_ready_s;
  logic [ADDR_W-1:0]   write_reg_r, write_reg_s;
  logic [DATA_W-1:0]   write_data_r, write_data_s;
  logic                reg_write_r, reg_write_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic [ADDR_W:0]     count_r, count_s;

  // Next-state and next-output logic; every output is computed one cycle
  // ahead so that all outputs come straight from flops.
  always_comb begin
    state_s      = state_r;
    index_s      = index_r;
    in_ready_s   = 1'b0;
    write_reg_s  = write_reg_r;
    write_data_s = write_data_r;
    reg_write_s  = 1'b0;
    busy_s       = 1'b0;
    done_s       = 1'b0;
    count_s      = count_r;

    case (state_r)
      IDLE: begin
        if (Start) begin
          state_s    = LOAD;
          index_s    = FIRST_IDX;
          count_s    = '0;
          in_ready_s = 1'b1;
          busy_s     = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end

      LOAD: begin
        // Abort wins over a beat presented in the same cycle.
        if (Abort) begin
          state_s = IDLE;
        end else begin
          in_ready_s = 1'b1;
          busy_s     = 1'b1;
          if (In_Valid && in_ready_r) begin
            write_reg_s  = index_r;
            write_data_s = In_Data;
            reg_write_s  = 1'b1;
            count_s      = count_r + CNT_ONE;
            // The last word drops In_Ready in the cycle its write appears,
            // so the index can never step past LAST_REG.
            if (index_r == LAST_IDX) begin
              state_s    = FLUSH;
              in_ready_s = 1'b0;
            end else begin
              index_s = index_r + IDX_ONE;
            end
          end else begin
            state_s = LOAD;
          end
        end
      end

      FLUSH: begin
        // The final write is on the port during this cycle.
        if (Abort) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
          done_s  = 1'b1;
        end
      end

      DONE: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r      <= IDLE;
      index_r      <= '0;
      in_ready_r   <= 1'b0;
      write_reg_r  <= '0;
      write_data_r <= '0;
      reg_write_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      count_r      <= '0;
    end else begin
      state_r      <= state_s;
      index_r      <= index_s;
      in_ready_r   <= in_ready_s;
      write_reg_r  <= write_reg_s;
      write_data_r <= write_data_s;
      reg_write_r  <= reg_write_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      count_r      <= count_s;
    end
  end

  assign In_Ready     = in_ready_r;
  assign Write_Reg    = write_reg_r;
  assign Write_Data   = write_data_r;
  assign Reg_Write    = reg_write_r;
  assign Busy         = busy_r;
  assign Done         = done_r;
  assign Loaded_Count = count_r;

endmodule

// File: tb/tb_reg_file_loader.sv
// Self-checking bench for reg_file_loader: a scoreboard queue holds the
// expected register writes and a negedge monitor compares every write
// the DUT issues; control outputs are checked directly by the stimulus.
module tb_reg_file_loader;
  import reg_file_loader_pkg::*;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (default parameters)
  logic        rst, start, abort_in, in_valid;
  logic [31:0] in_data;
  logic        in_ready, reg_write, busy, done;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [5:0]  loaded_count;

  // Single-register DUT (FIRST_REG = LAST_REG = 29)
  logic        b_rst, b_start, b_abort, b_in_valid;
  logic [31:0] b_in_data;
  logic        b_in_ready, b_reg_write, b_busy, b_done;
  logic [4:0]  b_write_reg;
  logic [31:0] b_write_data;
  logic [5:0]  b_loaded_count;

  reg_file_loader dut (
    .Clock(clk), .Reset(rst), .Start(start), .Abort(abort_in),
    .In_Data(in_data), .In_Valid(in_valid), .In_Ready(in_ready),
    .Write_Reg(write_reg), .Write_Data(write_data), .Reg_Write(reg_write),
    .Busy(busy), .Done(done), .Loaded_Count(loaded_count)
  );

  reg_file_loader #(.FIRST_REG(29), .LAST_REG(29)) dut_sp (
    .Clock(clk), .Reset(b_rst), .Start(b_start), .Abort(b_abort),
    .In_Data(b_in_data), .In_Valid(b_in_valid), .In_Ready(b_in_ready),
    .Write_Reg(b_write_reg), .Write_Data(b_write_data), .Reg_Write(b_reg_write),
    .Busy(b_busy), .Done(b_done), .Loaded_Count(b_loaded_count)
  );

  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          write_cnt = 0;
  int          exp_idx = 1;
  wr_t         exp_q[$];
  logic [31:0] rf[32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Register-file model plus scoreboard monitor for the main DUT.
  always @(negedge clk) begin
    wr_t e;
    if (done) done_cnt++;
    if (reg_write) begin
      rf[write_reg] = write_data;
      write_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write actual reg=%0d data=%0h expected no write",
                 write_reg, write_data);
      end else begin
        e = exp_q.pop_front();
        check("write_reg", 64'(write_reg), 64'(e.r));
        check("write_data", 64'(write_data), 64'(e.d));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_idx = 1;
    check("start_busy", 64'(busy), 64'd1);
    check("start_in_ready", 64'(in_ready), 64'd1);
    check("start_count", 64'(loaded_count), 64'd0);
  endtask

  task automatic beat(input logic v, input logic [31:0] d);
    check("beat_in_ready", 64'(in_ready), 64'd1);
    in_valid = v;
    in_data  = d;
    if (v) begin
      exp_q.push_back('{r: 5'(exp_idx), d: d});
      exp_idx++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Called in the cycle right after the last accepted beat (FLUSH).
  task automatic finish_load(input int wr0, input int dn0);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    check("flush_busy", 64'(busy), 64'd1);
    check("flush_done", 64'(done), 64'd0);
    check("flush_count", 64'(loaded_count), 64'd31);
    tick();
    check("done_pulse", 64'(done), 64'd1);
    check("done_busy", 64'(busy), 64'd0);
    check("done_reg_write", 64'(reg_write), 64'd0);
    tick();
    check("done_one_cycle", 64'(done), 64'd0);
    check("hold_count", 64'(loaded_count), 64'd31);
    check("write_total", 64'(write_cnt - wr0), 64'd31);
    check("done_total", 64'(done_cnt - dn0), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_rf(input int base);
    for (int i = 1; i <= 31; i++) begin
      check($sformatf("rf_r%0d", i), 64'(rf[i]), 64'(base + i - 1));
    end
    check("rf_r0", 64'(rf[REG_ZERO]), 64'd0);
  endtask

  initial begin
    int wr0, dn0;
    logic [31:0] saved;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rst = 1'b1; start = 1'b0; abort_in = 1'b0; in_valid = 1'b0; in_data = 32'd0;
    b_rst = 1'b1; b_start = 1'b0; b_abort = 1'b0; b_in_valid = 1'b0; b_in_data = 32'd0;
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_write_reg", 64'(write_reg), 64'd0);
    check("rst_write_data", 64'(write_data), 64'd0);
    check("rst_reg_write", 64'(reg_write), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_count", 64'(loaded_count), 64'd0);
    rst = 1'b0;
    b_rst = 1'b0;
    tick();

    // 1: 31 back-to-back beats
    wr0 = write_cnt; dn0 = done_cnt;
    start_load();
    for (int i = 0; i < 31; i++) beat(1'b1, 32'(100 + i));
    finish_load(wr0, dn0);
    check_rf(100);

    // In_Valid outside LOAD is dropped
    in_valid = 1'b1; in_data = 32'hDEADBEEF;
    tick();
    tick();
    check("idle_in_ready", 64'(in_ready), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    in_valid = 1'b0;

    // 2: bubble every other cycle
    wr0 = write_cnt; dn0 = done_cnt;
    start_load();
    for (int i = 0; i < 31; i++) begin
      beat(1'b1, 32'(200 + i));
      if (i != 30) beat(1'b0, 32'h0BADF00D);
    end
    check("no_early_done", 64'(done_cnt - dn0), 64'd0);
    finish_load(wr0, dn0);
    check_rf(200);

    // 3: Start re-pulsed during LOAD is ignored
    wr0 = write_cnt; dn0 = done_cnt;
    start_load();
    for (int i = 0; i < 31; i++) begin
      if (i == 5) start = 1'b1;
      beat(1'b1, 32'(300 + i));
      start = 1'b0;
    end
    finish_load(wr0, dn0);
    check_rf(300);

    // 4: Abort after 10 accepts with a valid beat in the Abort cycle
    wr0 = write_cnt; dn0 = done_cnt;
    saved = rf[11];
    start_load();
    for (int i = 0; i < 10; i++) beat(1'b1, 32'(400 + i));
    abort_in = 1'b1; in_valid = 1'b1; in_data = 32'h12345678;
    tick();
    abort_in = 1'b0; in_valid = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_reg_write", 64'(reg_write), 64'd0);
    check("abort_count", 64'(loaded_count), 64'd10);
    tick();
    tick();
    check("abort_writes", 64'(write_cnt - wr0), 64'd10);
    check("abort_no_done", 64'(done_cnt - dn0), 64'd0);
    check("abort_r11_kept", 64'(rf[11]), 64'(saved));
    for (int i = 1; i <= 10; i++) check($sformatf("abort_r%0d", i), 64'(rf[i]), 64'(400 + i - 1));

    // 5: Reset after 3 accepts, then reload from r1
    wr0 = write_cnt;
    start_load();
    for (int i = 0; i < 3; i++) beat(1'b1, 32'(500 + i));
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hCAFEF00D;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_write_reg", 64'(write_reg), 64'd0);
    check("mid_rst_write_data", 64'(write_data), 64'd0);
    check("mid_rst_reg_write", 64'(reg_write), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_count", 64'(loaded_count), 64'd0);
    tick();
    check("mid_rst_writes", 64'(write_cnt - wr0), 64'd3);
    wr0 = write_cnt; dn0 = done_cnt;
    start_load();
    for (int i = 0; i < 31; i++) beat(1'b1, 32'(600 + i));
    finish_load(wr0, dn0);
    check_rf(600);

    // 6: single-register load of the stack pointer
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("sp_in_ready", 64'(b_in_ready), 64'd1);
    check("sp_busy", 64'(b_busy), 64'd1);
    b_in_valid = 1'b1; b_in_data = SP_RESET;
    tick();
    b_in_valid = 1'b0;
    check("sp_reg_write", 64'(b_reg_write), 64'd1);
    check("sp_write_reg", 64'(b_write_reg), 64'(REG_SP));
    check("sp_write_data", 64'(b_write_data), 64'(SP_RESET));
    check("sp_flush_in_ready", 64'(b_in_ready), 64'd0);
    check("sp_flush_busy", 64'(b_busy), 64'd1);
    check("sp_count", 64'(b_loaded_count), 64'd1);
    tick();
    check("sp_done", 64'(b_done), 64'd1);
    check("sp_done_busy", 64'(b_busy), 64'd0);
    check("sp_no_second_write", 64'(b_reg_write), 64'd0);
    tick();
    check("sp_done_cleared", 64'(b_done), 64'd0);
    check("sp_count_hold", 64'(b_loaded_count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_loader.md
Name: reg_file_loader

Overview:
- Sequential writer that preloads the 32x32 register file through its single write port, one word per accepted input beat.
- Runs before program execution, for example to restore a saved register image. It is the load-side counterpart of the end-of-run register dump.
- Sits beside the CPU datapath. While Busy is high, the top level muxes this block's Write_Reg, Write_Data and Reg_Write over the CPU's and stalls the CPU.

Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register index width
- FIRST_REG, 1, first register written; register 0 ($zero) is skipped by default
- LAST_REG, 31, last register written; FIRST_REG <= LAST_REG is required

Ports:
- Clock  input  1  system clock; all state updates on posedge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  one-cycle request to begin a load sequence
- Abort  input  1  cancels an in-progress load
- In_Data  input  DATA_W  next register value to load
- In_Valid  input  1  In_Data is valid
- In_Ready  output  1  block accepts In_Data this cycle
- Write_Reg  output  ADDR_W  register-file write index
- Write_Data  output  DATA_W  register-file write data
- Reg_Write  output  1  register-file write enable
- Busy  output  1  load in progress; the write-port mux selects this block
- Done  output  1  one-cycle pulse when a load completes
- Loaded_Count  output  ADDR_W+1  number of words written in the current or most recent load

Behaviour:
- All outputs are registered. Reset values are all 0: In_Ready, Write_Reg, Write_Data, Reg_Write, Busy, Done and Loaded_Count.
- Reset has priority over every other input and returns the FSM to IDLE.
- FSM states are IDLE, LOAD, FLUSH and DONE.
- IDLE:
  - Start=1 moves to LOAD, sets the index to FIRST_REG and clears Loaded_Count.
  - Otherwise the FSM stays in IDLE.
- LOAD:
  - In_Ready=1 and Busy=1.
  - An accept is In_Valid & In_Ready at a posedge.
  - On an accept at posedge k: in cycle k+1, Write_Reg=index, Write_Data=In_Data and Reg_Write=1; Loaded_Count increments.
  - The register file samples the write on the negedge inside cycle k+1.
  - Back-to-back accepts are allowed, so Reg_Write may stay high on consecutive cycles with consecutive indices.
  - A cycle with no accept gives Reg_Write=0 next cycle; Write_Reg and Write_Data hold their previous values.
  - If the accept had index == LAST_REG, the FSM moves to FLUSH and In_Ready drops in the same cycle the last write appears. Otherwise the index increments.
- FLUSH:
  - Lasts one cycle. Busy=1, In_Ready=0, and Reg_Write=1 for the final word.
  - Then moves to DONE.
- DONE:
  - Done=1 and Busy=0 for exactly one cycle, then the FSM returns to IDLE.
  - Loaded_Count holds LAST_REG-FIRST_REG+1 until the next Start.
- Total latency for N words with no bubbles: first accept to Done is N+1 cycles.
- Start in any state other than IDLE is ignored.
- Abort in LOAD or FLUSH:
  - The FSM returns to IDLE on the next posedge with In_Ready=0, Busy=0 and Done=0.
  - A write already registered completes in its cycle; no further writes are issued.
  - An In_Valid beat presented in the same cycle as Abort is not accepted.
  - Loaded_Count keeps the number of words actually written.
- Abort in IDLE or DONE has no effect.
- Reset in the middle of a load behaves like Abort, except that Loaded_Count and the write outputs are also cleared.
- The index never wraps: no write is issued beyond LAST_REG, and In_Ready is 0 outside LOAD.
- In_Valid outside LOAD is ignored; the data is dropped and no error is raised.

Decomposition:
- Shared package holds:
  - the state encoding constants IDLE, LOAD, FLUSH, DONE
  - REG_ZERO=0 and REG_SP=29, with SP_RESET=32'h00001FFF for images that restore the stack pointer
  - DATA_W and ADDR_W defaults
- Single module; no sub-module is warranted.
- The write-port mux lives at the top level, not in this block.

Test Plan:
- Default params; Start, then 31 back-to-back beats with values 100+i -> Reg_Write high for 31 consecutive cycles, Write_Reg 1..31, Done pulse one cycle after the last write, Loaded_Count=31, register file r1=100..r31=130, r0=0.
- In_Valid low every other cycle -> Reg_Write toggles in step with accepts, indices strictly sequential, Done only after index 31 is written.
- Start pulsed again during LOAD after 5 words -> ignored, index keeps counting from 6, exactly 31 writes in total.
- Abort after 10 accepts, with In_Valid=1 in the Abort cycle -> 10 writes only (r1..r10), no Done, Busy=0 next cycle, Loaded_Count=10, r11 unchanged.
- Reset asserted after 3 accepts -> all outputs 0 on the next cycle, no 4th write; a new Start then loads again from r1.
- FIRST_REG=LAST_REG=29, one beat of 32'h00001FFF -> a single write to r29, FLUSH then Done, Loaded_Count=1.
